rapid_mem_arbiter: RTL

Shares the single cache/memory port between two requesters: the instruction-fetch stage (word reads only) and the data-memory stage (byte, half-word or word reads and writes). It is a single-outstanding-transaction controller. Data requests have priority, with a starvation guard so fetch always makes progress. It also handles fetch flush on branch redirect, and rejects misaligned data accesses locally without sending them to the port.

---
 rtl/rapid_mem_arbiter_pkg.sv | 41 ++++
 rtl/rapid_mem_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rapid_mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter.
//   cache_rw / cache_operation : direction and size of a cache-port access
//   arb_state_t                : arbiter FSM states
//   is_misaligned()            : size/address alignment check for data accesses
package rapid_mem_arbiter_pkg;

    localparam int unsigned WORD_WIDTH = 4;  // bytes per word
    localparam int unsigned DATA_WIDTH = WORD_WIDTH * 8;

    typedef enum logic {
        CACHE_READ  = 1'b0,
        CACHE_WRITE = 1'b1
    } cache_rw;

    typedef enum logic [1:0] {
        CACHE_NOP = 2'd0,
        BYTE      = 2'd1,
        HALF_WORD = 2'd2,
        WORD      = 2'd3
    } cache_operation;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_IF,
        ARB_DM,
        ARB_ERR
    } arb_state_t;

    // Byte accesses and CACHE_NOP are never misaligned.
    function automatic logic is_misaligned(cache_operation op, logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (op)
            HALF_WORD: bad = addr_lo[0];
            WORD:      bad = (addr_lo != 2'b00);
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/rapid_mem_arbiter.sv
// Single-outstanding arbiter sharing one cache/memory port between instruction
// fetch and the data-memory stage. Data wins ties unless fetch has been passed
// over STARVE_LIMIT times in a row. Misaligned and NOP data accesses are
// answered locally and never reach the port.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   if_req/if_addr/if_flush   fetch request, word address, flush/redirect
//   if_gnt/if_rvalid/if_rdata fetch grant (comb), read response (registered)
//   dm_req/rw/op/addr/wdata   data request fields
//   dm_gnt/dm_rvalid/dm_rdata/dm_err  data grant (comb), completion response
//   mem_req/rw/op/addr/wdata  port request, held until mem_done
//   mem_done/mem_rdata        port completion pulse and read data
module rapid_mem_arbiter
    import rapid_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  dm_req,
    input  cache_rw               dm_rw,
    input  cache_operation        dm_op,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_gnt,
    output logic                  dm_rvalid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_err,
    output logic                  mem_req,
    output cache_rw               mem_rw,
    output cache_operation        mem_op,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_done,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int unsigned CntW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    arb_state_t            state_q, state_d;
    logic [CntW-1:0]       starve_cnt_q, starve_cnt_d;
    logic                  drop_q, drop_d;
    logic                  if_rvalid_q, if_rvalid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic                  dm_rvalid_q, dm_rvalid_d;
    logic                  dm_err_q, dm_err_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    cache_rw               mem_rw_q, mem_rw_d;
    cache_operation        mem_op_q, mem_op_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic arb_idle, if_elig, force_if, dm_bad, dm_local, if_done, dm_done;

    always_comb begin
        // Grants are held off during reset so every output reads 0 while rst is high.
        arb_idle = (state_q == ARB_IDLE) && !rst;
        if_elig  = if_req && !if_flush;
        force_if = (STARVE_LIMIT != 0) && (starve_cnt_q == CntMax);
        dm_bad   = is_misaligned(dm_op, dm_addr[1:0]);
        dm_local = dm_bad || (dm_op == CACHE_NOP);
        dm_gnt   = arb_idle && dm_req && !(if_elig && force_if);
        if_gnt   = arb_idle && if_elig && !dm_gnt;
        if_done  = (state_q == ARB_IF) && mem_done;
        dm_done  = (state_q == ARB_DM) && mem_done;
    end

    // Next-state and capture logic.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        drop_d       = 1'b0;
        mem_rw_d     = mem_rw_q;
        mem_op_d     = mem_op_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ARB_IDLE: begin
                if (dm_gnt) begin
                    state_d = dm_local ? ARB_ERR : ARB_DM;
                end else if (if_gnt) begin
                    state_d = ARB_IF;
                end
            end
            ARB_IF, ARB_DM: begin
                if (mem_done) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ERR: state_d = ARB_IDLE;
            default: state_d = ARB_IDLE;
        endcase

        if (!if_req || if_gnt) begin
            starve_cnt_d = '0;
        end else if (dm_gnt && (starve_cnt_q != CntMax)) begin
            starve_cnt_d = starve_cnt_q + CntW'(1);
        end

        // A flush while fetching poisons the response; cleared when the fetch ends.
        if ((state_q == ARB_IF) && !mem_done) begin
            drop_d = drop_q || if_flush;
        end

        if (dm_gnt && !dm_local) begin
            mem_rw_d    = dm_rw;
            mem_op_d    = dm_op;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
        end else if (if_gnt) begin
            mem_rw_d   = CACHE_READ;
            mem_op_d   = WORD;
            mem_addr_d = if_addr;
        end
    end

    // Response registers: one-cycle pulses the cycle after completion.
    always_comb begin
        if_rvalid_d = if_done && !drop_q && !if_flush;
        if_rdata_d  = if_rvalid_d ? mem_rdata : if_rdata_q;
        dm_rvalid_d = dm_done || (dm_gnt && dm_local);
        dm_err_d    = dm_gnt && dm_bad;
        dm_rdata_d  = dm_rdata_q;
        if (dm_done) begin
            dm_rdata_d = (mem_rw_q == CACHE_READ) ? mem_rdata : '0;
        end else if (dm_gnt && dm_local) begin
            dm_rdata_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
            drop_q       <= 1'b0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            dm_rvalid_q  <= 1'b0;
            dm_err_q     <= 1'b0;
            dm_rdata_q   <= '0;
            mem_rw_q     <= CACHE_READ;
            mem_op_q     <= CACHE_NOP;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            drop_q       <= drop_d;
            if_rvalid_q  <= if_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            dm_rvalid_q  <= dm_rvalid_d;
            dm_err_q     <= dm_err_d;
            dm_rdata_q   <= dm_rdata_d;
            mem_rw_q     <= mem_rw_d;
            mem_op_q     <= mem_op_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign mem_req   = (state_q == ARB_IF) || (state_q == ARB_DM);
    assign mem_rw    = mem_rw_q;
    assign mem_op    = mem_op_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rvalid = dm_rvalid_q;
    assign dm_err    = dm_err_q;
    assign dm_rdata  = dm_rdata_q;

endmodule
